// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - time-multiplexed 7-segment scan controller
// Shares one hex decoder across NUM_DIGITS digits with blanking and frame-aligned value commits.
module disp_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    idle_i,
  input  logic                    lz_en_i,
  output logic                    load_ack_o,
  output logic                    frame_o,
  output logic [3:0]              dec_val_o,
  output logic                    dec_idle_o,
  output logic [NUM_DIGITS-1:0]   digit_en_n_o
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic                  w_commit;
  logic [DW-1:0]         r_active, r_pending;
  logic                  r_pend_valid;
  logic [3:0]            r_dec_val;
  logic                  r_dec_idle, r_frame, r_ack;
  logic [3:0]            w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_supp, w_en_n;
  logic                  w_zero_run;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    w_commit    = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_commit  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
    endcase
  end

  // Suppression walks down from the most significant digit while nibbles stay zero.
  always_comb begin
    w_supp     = '0;
    w_zero_run = lz_en_i & ~idle_i;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_nib[k] = r_active[4*k +: 4];
    end
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_zero_run = w_zero_run & (w_nib[k] == 4'd0);
      w_supp[k]  = w_zero_run;
    end
  end

  always_comb begin
    w_en_n = '1;
    if (r_state == ST_SHOW && !w_supp[r_idx]) begin
      w_en_n[r_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_dec_val    <= 4'd0;
      r_dec_idle   <= 1'b0;
      r_frame      <= 1'b0;
      r_ack        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_dec_val  <= w_nib[r_idx];
      r_dec_idle <= idle_i;
      r_frame    <= w_commit;
      r_ack      <= w_commit & r_pend_valid;
      if (w_commit && r_pend_valid) begin
        r_active <= r_pending;
      end
      // A load on the commit edge keeps valid set: the old value commits, the new one waits.
      if (load_i) begin
        r_pending    <= value_i;
        r_pend_valid <= 1'b1;
      end else if (w_commit) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign digit_en_n_o = w_en_n;
  assign dec_val_o    = r_dec_val;
  assign dec_idle_o   = r_dec_idle;
  assign frame_o      = r_frame;
  assign load_ack_o   = r_ack;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - scoreboard bench for disp_scan_ctrl
// Time-based reference model pushes expected outputs per cycle; a monitor pops and compares.
module tb_disp_scan_ctrl;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = DWELL + BLANK;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst, load_i, idle_i, lz_en_i;
  logic [15:0] value_i;
  logic        load_ack_o, frame_o, dec_idle_o;
  logic [3:0]  dec_val_o, digit_en_n_o;

  disp_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_i),
    .value_i     (value_i),
    .idle_i      (idle_i),
    .lz_en_i     (lz_en_i),
    .load_ack_o  (load_ack_o),
    .frame_o     (frame_o),
    .dec_val_o   (dec_val_o),
    .dec_idle_o  (dec_idle_o),
    .digit_en_n_o(digit_en_n_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] val;
    logic       idle;
    logic       frame;
    logic       ack;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_ack  = 0;
  int          m_c    = 0;
  logic [15:0] m_act, m_pend;
  logic        m_pv;

  function automatic logic [3:0] exp_en(int c, logic [15:0] act, logic lz, logic idl);
    int slot;
    int pos;
    slot = (c % FRAME) / SLOT;
    pos  = c % SLOT;
    if (pos < BLANK) return 4'hF;
    if (lz && !idl && slot > 0 && (act >> (4 * slot)) == 16'h0) return 4'hF;
    return ~(4'b0001 << slot);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, m_c, obs, expv);
    end
  endtask

  // Reference model: runs at the edge, reads only stimulus and its own state.
  always @(posedge clk) begin : model
    exp_t e;
    int   ps;
    if (rst) begin
      m_c    = 0;
      m_act  = 16'h0;
      m_pend = 16'h0;
      m_pv   = 1'b0;
      e      = '{en: 4'hF, val: 4'h0, idle: 1'b0, frame: 1'b0, ack: 1'b0};
    end else begin
      ps      = (m_c % FRAME) / SLOT;
      e.val   = m_act[ps*4 +: 4];
      e.idle  = idle_i;
      m_c     = m_c + 1;
      e.frame = ((m_c % FRAME) == 0);
      e.ack   = e.frame && m_pv;
      if (e.ack) m_act = m_pend;
      if (load_i) begin
        m_pend = value_i;
        m_pv   = 1'b1;
      end else if (e.frame) begin
        m_pv = 1'b0;
      end
      e.en = exp_en(m_c, m_act, lz_en_i, idle_i);
    end
    q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (load_ack_o === 1'b1) n_ack++;
    checks++;
    assert ($countones(~digit_en_n_o) <= 1) else begin
      errors++;
      $error("FAIL onehot at cycle %0d: observed %b expected at most one low", m_c, digit_en_n_o);
    end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty at cycle %0d: observed empty expected entry", m_c);
    end else begin
      e = q.pop_front();
      chk("digit_en_n", digit_en_n_o, e.en);
      chk("dec_val", dec_val_o, e.val);
      chk("dec_idle", {3'b0, dec_idle_o}, {3'b0, e.idle});
      chk("frame", {3'b0, frame_o}, {3'b0, e.frame});
      chk("load_ack", {3'b0, load_ack_o}, {3'b0, e.ack});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    value_i = v;
    load_i  = 1'b1;
    @(negedge clk);
    load_i  = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((m_c % FRAME) != ph && n < 4 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert ((m_c % FRAME) == ph) else begin
      errors++;
      $error("FAIL wait_phase: observed %0d expected %0d", m_c % FRAME, ph);
    end
  endtask

  task automatic chk_acks(input string tag, input int got, input int want);
    checks++;
    assert (got == want) else begin
      errors++;
      $error("FAIL %s: observed %0d acks expected %0d", tag, got, want);
    end
  endtask

  initial begin
    int a0;
    rst     = 1'b1;
    load_i  = 1'b0;
    value_i = 16'h0;
    idle_i  = 1'b0;
    lz_en_i = 1'b0;
    step(3);
    rst = 1'b0;
    step(50);

    a0 = n_ack;
    wait_phase(10);
    load(16'h1234);
    step(2 * FRAME);
    chk_acks("ack_1234", n_ack - a0, 1);

    lz_en_i = 1'b1;
    wait_phase(5);
    load(16'h0050);
    step(2 * FRAME);
    wait_phase(5);
    load(16'h0000);
    step(2 * FRAME);

    idle_i = 1'b1;
    step(FRAME + 6);
    idle_i  = 1'b0;
    lz_en_i = 1'b0;

    a0 = n_ack;
    wait_phase(1);
    load(16'hAAAA);
    step(2);
    load(16'hBBBB);
    step(FRAME + 4);
    chk_acks("ack_b2b", n_ack - a0, 1);

    a0 = n_ack;
    wait_phase(8);
    load(16'hCCCC);
    wait_phase(FRAME - 1);
    load(16'hDDDD);
    step(FRAME + 4);
    chk_acks("ack_commit_edge", n_ack - a0, 2);

    wait_phase(3);
    load(16'hEEEE);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    a0 = n_ack;
    step(FRAME + 8);
    chk_acks("ack_after_reset", n_ack - a0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-segment 7-segment display bank.
- Sequences one shared hex decoder (4-bit value plus IDLE input; IDLE shows a dash) across NUM_DIGITS digits.
- Drives active-low digit enables with inter-digit blanking, optional leading-zero suppression, and tear-free value updates committed only at frame boundaries.

Parameters:
- NUM_DIGITS, 4: digits scanned; digit 0 is least significant; minimum 2.
- DWELL_CYCLES, 50000: clocks each digit is lit per slot; minimum 1.
- BLANK_CYCLES, 4: clocks with all digits off before each slot; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_i  in  1  one-cycle strobe; capture value_i into the pending register
- value_i  in  4*NUM_DIGITS  nibble k drives digit k
- idle_i  in  1  display dash on all digits; suppression is disabled while high
- lz_en_i  in  1  enable leading-zero suppression
- load_ack_o  out  1  one-cycle pulse when a pending value commits to the display
- frame_o  out  1  one-cycle pulse at the start of each scan frame
- dec_val_o  out  4  nibble to the shared decoder Val input
- dec_idle_o  out  1  to the shared decoder IDLE input
- digit_en_n_o  out  NUM_DIGITS  active-low digit enables; at most one bit is low at a time

Behaviour:
- Reset values:
  - digit_en_n_o all 1s; dec_val_o 0; dec_idle_o 0; load_ack_o 0; frame_o 0.
  - Active register 0; pending register 0; pending_valid 0.
  - Digit index 0; state BLANK; cycle counter 0.
- Reset asserted mid-scan: applies the reset values on the next edge. Any uncommitted pending value is discarded and no ack is issued.
- FSM, two states:
  - BLANK: all enables high; counter runs 0..BLANK_CYCLES-1, then go to SHOW with counter 0.
  - SHOW: digit_en_n_o[idx] is low unless idx is suppressed; counter runs 0..DWELL_CYCLES-1, then go to BLANK with idx+1.
  - idx wraps from NUM_DIGITS-1 to 0.
- Timing:
  - Slot length = BLANK_CYCLES+DWELL_CYCLES.
  - Frame length = NUM_DIGITS × slot length.
  - After reset release, the first enable goes low at cycle BLANK_CYCLES.
- Decoder drive:
  - dec_val_o and dec_idle_o are registered from active[idx] and idle_i every cycle, giving a one-cycle lag.
  - BLANK_CYCLES ≥ 2 guarantees both are stable before the enable falls.
  - Suppressed slots still take the full dwell time with enables held high, so brightness stays uniform.
- Leading-zero suppression:
  - Applies when lz_en_i=1 and idle_i=0.
  - Digit k (k≥1) is suppressed when active nibbles NUM_DIGITS-1 down to k are all 0.
  - Digit 0 is never suppressed.
  - Evaluated from the active register only.
- Load/commit:
  - load_i=1 writes value_i to pending and sets pending_valid.
  - A repeat load_i while pending_valid=1 overwrites pending (last write wins).
  - Commit point is the SHOW(last digit)→BLANK(digit 0) edge. frame_o=1 on that cycle.
  - If pending_valid was 1 before that edge: active ← pending, pending_valid ← 0, load_ack_o=1 on the same cycle as frame_o.
  - If load_i arrives on the commit edge itself, the old pending commits and the new value becomes pending for the next frame.
  - With no prior pending, the new value waits one full frame.
- Wrap-around: idx and counters wrap silently. At most one load_ack_o per frame.

Test Plan:
(Use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2 for all scenarios.)
- Reset release:
  - 2 cycles all enables high, then digit_en_n_o=4'b1110 for 4 cycles, then 2 blank cycles, then 4'b1101.
  - frame_o pulses every 24 cycles.
- Load 0x1234 mid-frame:
  - load_ack_o and frame_o pulse together at the next boundary.
  - Next frame: dec_val_o = 4, 3, 2, 1 during the digit 0..3 slots.
  - dec_val_o is stable 1 cycle before each enable falls.
- Leading zeros: lz_en_i=1, value 0x0050 committed.
  - Digits 3 and 2 remain high through their slots; digits 1 and 0 light.
  - Value 0x0000 lights only digit 0.
- idle_i=1 with value 0x0000 and lz_en_i=1:
  - dec_idle_o=1 and all four digits light in sequence (no suppression).
- Back-to-back loads 0xAAAA then 0xBBBB in one frame:
  - Single ack; the display shows 0xBBBB.
  - A load on the exact commit edge appears one frame later with its own ack.
- Reset mid-SHOW with a pending load:
  - Enables go all-high the next cycle.
  - No load_ack_o; the display restarts at digit 0 showing 0.
